incline_avg: RTL and testbench



---
 rtl/incline_avg.sv | 131 +++++++++++++
 tb/tb_incline_avg.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/incline_avg.sv
// Incline smoother: saturates each accepted sample and keeps a sliding-window
// average over the last 2^LOG2_DEPTH saturated samples, with a window-full flag.
module incline_avg #(
  parameter int SAT_W      = 10,
  parameter int LOG2_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    vld,
  input  logic signed [12:0]      incline,
  input  logic                    clr,
  output logic signed [SAT_W-1:0] incline_sat,
  output logic signed [SAT_W-1:0] avg,
  output logic                    avg_vld,
  output logic                    full
);

  localparam int DEPTH = 1 << LOG2_DEPTH;
  localparam int ACC_W = SAT_W + LOG2_DEPTH;
  localparam int CNT_W = LOG2_DEPTH + 1;
  localparam logic signed [12:0] SAT_MAX = 13'((1 << (SAT_W - 1)) - 1);
  localparam logic signed [12:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {S_EMPTY, S_FILL, S_RUN} state_t;

  state_t                    r_state, w_state_nxt;
  logic [CNT_W-1:0]          r_cnt, w_cnt_nxt;
  logic [LOG2_DEPTH-1:0]     r_wr_ptr;
  logic signed [SAT_W-1:0]   r_buf [DEPTH];
  logic signed [ACC_W-1:0]   r_acc;
  logic signed [ACC_W-1:0]   w_acc_nxt;
  logic signed [SAT_W-1:0]   w_sat;
  logic signed [SAT_W-1:0]   w_old;
  logic                      w_accept;
  logic                      w_avg_upd;
  logic signed [SAT_W-1:0]   r_incline_sat;
  logic signed [SAT_W-1:0]   r_avg;
  logic                      r_avg_vld;
  logic                      r_full;

  function automatic logic signed [SAT_W-1:0] sat_f(input logic signed [12:0] x);
    if (x > SAT_MAX)      return SAT_MAX[SAT_W-1:0];
    else if (x < SAT_MIN) return SAT_MIN[SAT_W-1:0];
    else                  return x[SAT_W-1:0];
  endfunction

  // Arithmetic shift floors toward -infinity; the quotient always fits SAT_W.
  function automatic logic signed [SAT_W-1:0] avg_f(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] s;
    s = a >>> LOG2_DEPTH;
    return s[SAT_W-1:0];
  endfunction

  assign w_sat     = sat_f(incline);
  assign w_old     = r_buf[r_wr_ptr];
  assign w_accept  = vld & ~clr;
  assign w_acc_nxt = r_acc + ACC_W'(w_sat) - ACC_W'(w_old);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_avg_upd   = 1'b0;
    if (clr) begin
      w_state_nxt = S_EMPTY;
      w_cnt_nxt   = '0;
    end else if (vld) begin
      case (r_state)
        S_EMPTY: begin
          w_state_nxt = S_FILL;
          w_cnt_nxt   = CNT_W'(1);
        end
        S_FILL: begin
          w_cnt_nxt = r_cnt + 1'b1;
          if (r_cnt == CNT_W'(DEPTH - 1)) begin
            w_state_nxt = S_RUN;
            w_avg_upd   = 1'b1;
          end
        end
        S_RUN:   w_avg_upd   = 1'b1;
        default: w_state_nxt = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_EMPTY;
      r_cnt   <= '0;
      r_full  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_full  <= (w_state_nxt == S_RUN);
    end
  end

  // Window storage: the slot being overwritten leaves the sum as the new sample enters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_buf[i] <= '0;
      r_acc    <= '0;
      r_wr_ptr <= '0;
    end else if (clr) begin
      for (int i = 0; i < DEPTH; i++) r_buf[i] <= '0;
      r_acc    <= '0;
      r_wr_ptr <= '0;
    end else if (vld) begin
      r_buf[r_wr_ptr] <= w_sat;
      r_acc           <= w_acc_nxt;
      r_wr_ptr        <= r_wr_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_incline_sat <= '0;
      r_avg         <= '0;
      r_avg_vld     <= 1'b0;
    end else begin
      r_avg_vld <= w_avg_upd;
      if (w_accept)  r_incline_sat <= w_sat;
      if (w_avg_upd) r_avg         <= avg_f(w_acc_nxt);
    end
  end

  assign incline_sat = r_incline_sat;
  assign avg         = r_avg;
  assign avg_vld     = r_avg_vld;
  assign full        = r_full;

endmodule

// File: tb/tb_incline_avg.sv
// Scoreboard bench for incline_avg: stimulus queues hand-computed expectations,
// a monitor pops and compares them one cycle after each accepted sample.
module tb_incline_avg;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              vld = 1'b0;
  logic              clr = 1'b0;
  logic signed [12:0] incline = '0;
  logic signed [9:0] incline_sat;
  logic signed [9:0] avg;
  logic              avg_vld;
  logic              full;

  incline_avg #(.SAT_W(10), .LOG2_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .vld(vld), .incline(incline), .clr(clr),
    .incline_sat(incline_sat), .avg(avg), .avg_vld(avg_vld), .full(full)
  );

  always #5 clk = ~clk;

  typedef struct {
    int sat;
    bit has_avg;
    int avg;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   n_cmp  = 0;
  int   n_fail = 0;
  bit   acc_prev = 1'b0;

  int sl1[8]  = '{87, 75, 62, 50, 37, 25, 12, 0};
  int sl2[16] = '{-13, -25, -38, -50, -63, -75, -88, -100,
                  -100, -100, -100, -100, -100, -100, -100, -100};

  task automatic chk(input string name, input logic signed [31:0] act,
                     input logic signed [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic send(input int x, input int es, input bit ha, input int ea);
    vld     = 1'b1;
    incline = 13'(x);
    sbq.push_back(exp_t'{es, ha, ea});
    @(negedge clk);
    vld = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_clr();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) acc_prev <= 1'b0;
    else     acc_prev <= vld && !clr;
  end

  always @(negedge clk) begin
    if (acc_prev) begin
      if (sbq.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL sb_empty: got output with no queued expectation, required none pending");
      end else begin
        mon_e = sbq.pop_front();
        chk("incline_sat", incline_sat, mon_e.sat);
        chk("avg_vld", avg_vld, mon_e.has_avg);
        if (mon_e.has_avg) chk("avg", avg, mon_e.avg);
      end
    end else if (!rst) begin
      chk("avg_vld_idle", avg_vld, 0);
    end
  end

  initial begin
    #1 rst = 1'b1;
    vld = 1'b1;
    incline = 13'sd200;
    repeat (3) @(negedge clk);
    chk("rst_sat", incline_sat, 0);
    chk("rst_avg", avg, 0);
    chk("rst_avg_vld", avg_vld, 0);
    chk("rst_full", full, 0);
    rst = 1'b0;
    vld = 1'b0;
    idle(2);

    // Saturation at both rails and pass-through
    send(4095, 511, 0, 0);
    send(-4096, -512, 0, 0);
    send(300, 300, 0, 0);
    idle(2);
    do_clr();
    idle(1);
    chk("clr_full", full, 0);
    chk("clr_keep_sat", incline_sat, 300);

    // Fill with 100, three clocks apart
    for (int i = 0; i < 16; i++) begin
      send(100, 100, (i == 15), 100);
      if (i == 14) chk("fill15_full", full, 0);
      if (i == 15) chk("fill16_full", full, 1);
      idle(2);
    end

    // Slide in -100 and wrap the pointer
    for (int i = 0; i < 8; i++) send(-100, -100, 1, sl1[i]);
    for (int i = 0; i < 16; i++) send(-100, -100, 1, sl2[i]);
    chk("run_full", full, 1);

    // clr together with vld: sample discarded
    vld = 1'b1;
    clr = 1'b1;
    incline = 13'sd77;
    @(negedge clk);
    vld = 1'b0;
    clr = 1'b0;
    chk("clrvld_full", full, 0);
    chk("clrvld_sat", incline_sat, -100);
    chk("clrvld_avg_vld", avg_vld, 0);
    chk("clrvld_avg_hold", avg, -100);

    // Floor rounding of small sums
    for (int i = 0; i < 15; i++) send(0, 0, 0, 0);
    send(-1, -1, 1, -1);
    send(1, 1, 1, 0);
    idle(1);

    // Back-to-back full-scale fill
    do_clr();
    for (int i = 0; i < 16; i++) send(511, 511, (i == 15), 511);
    chk("b2b_full", full, 1);
    idle(1);

    // Async reset mid-fill
    do_clr();
    for (int i = 0; i < 5; i++) send(20, 20, 0, 0);
    idle(1);
    #2 rst = 1'b1;
    #1;
    chk("arst_sat", incline_sat, 0);
    chk("arst_avg", avg, 0);
    chk("arst_full", full, 0);
    @(negedge clk);
    rst = 1'b0;
    idle(1);
    for (int i = 0; i < 16; i++) send(50, 50, (i == 15), 50);

    for (int k = 0; k < 10 && sbq.size() != 0; k++) @(negedge clk);
    chk("sb_drain", sbq.size(), 0);
    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
